primo_control: RTL and testbench

- Control FSM for the primality datapath, directly upstream of it.
- On `start`, sequences the datapath select lines a1..a7 through repeated-subtraction divisibility tests of `n` by every K from n-1 down to 1.
- The datapath counts divisors in C; this FSM freezes the result on P when the count is finished.
- Reads the datapath's A and K registers back as status. Provides a start/busy/done handshake and a cycle counter.

---
 rtl/primo_control.sv | 105 ++++++++++
 tb/tb_primo_control.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/primo_control.sv
// Control FSM for the primality datapath: walks K from n-1 down to 1, testing
// divisibility of n by repeated subtraction, and freezes P when the walk ends.
module primo_control #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  n,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  K,
  output logic          a1,
  output logic          a2,
  output logic          a3,
  output logic          a4,
  output logic          a5,
  output logic          a6,
  output logic          a7,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycles,
  output logic [1:0]    fsm_state
);

  // Handshake: start is accepted only in IDLE; busy is high from the next
  // cycle through FINISH, and done pulses for exactly the FINISH cycle.
  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    SUB    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state, state_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycles <= '0;
    end else if (state == IDLE && start) begin
      cycles <= '0;
    end else if (state == SUB && cycles != '1) begin
      cycles <= cycles + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    a1 = 1'b0;
    a2 = 1'b0;
    a3 = 1'b0;
    a4 = 1'b0;
    a5 = 1'b0;
    a6 = 1'b0;
    a7 = 1'b0;
    case (state)
      INIT: begin
        state_nx = IDLE;
      end
      IDLE: begin
        a4 = 1'b1;
        a7 = 1'b1;
        // n<2 skips SUB so K=n-1 never wraps to all-ones for n=0.
        if (start) state_nx = (n >= W'(2)) ? SUB : FINISH;
      end
      SUB: begin
        a7 = 1'b1;
        if (K == '0) begin
          a2 = 1'b1;
          a4 = 1'b1;
          a6 = 1'b1;
          state_nx = FINISH;
        end else if (A >= K) begin
          a1 = 1'b1;
          a2 = 1'b1;
          a4 = 1'b1;
          a6 = 1'b1;
        end else if (A == '0) begin
          a3 = 1'b1;
          a5 = 1'b1;
        end else begin
          a3 = 1'b1;
          a6 = 1'b1;
        end
      end
      FINISH: begin
        a2 = 1'b1;
        a4 = 1'b1;
        a6 = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = INIT;
    endcase
  end

  assign busy      = !rst && (state == SUB || state == FINISH);
  assign done      = !rst && (state == FINISH);
  assign fsm_state = state;

endmodule

// File: tb/tb_primo_control.sv
// Bench for primo_control: a behavioural datapath closes the loop, directed
// runs push hand-computed results, and a monitor checks them on each done.
module tb_primo_control;
  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  n = '0;
  logic [W-1:0]  dA = '0, dK = '0, dE = '0, dC = '0;
  logic          dP = 1'b0;
  logic          a1, a2, a3, a4, a5, a6, a7;
  logic          busy, done;
  logic [CW-1:0] cycles;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int resp_cnt = 0;

  logic [CW-1:0] exp_cyc_q[$];
  logic [31:0]   exp_t_q[$];
  logic          exp_p_q[$];
  logic          p_pending = 1'b0;
  logic          p_exp = 1'b0;

  primo_control #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .A(dA), .K(dK),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
    .busy(busy), .done(done), .cycles(cycles), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // datapath driven by the select lines
  always @(posedge clk) begin
    dA <= a1 ? dA - dK : n;
    dK <= a2 ? dK : (a3 ? dK - 1'b1 : n - 1'b1);
    dE <= a4 ? dE : dA;
    dC <= a6 ? dC : (a5 ? dC + 1'b1 : 8'd1);
    dP <= a7 ? dP : (dC == 8'd2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (p_pending) begin
      p_pending = 1'b0;
      check("p_result", 32'(dP), 32'(p_exp));
    end
    if (done) begin
      if (exp_cyc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc_cnt);
      end else begin
        check("cycles", 32'(cycles), 32'(exp_cyc_q.pop_front()));
        check("done_time", 32'(cyc_cnt), exp_t_q.pop_front());
        check("busy_at_done", 32'(busy), 32'd1);
        p_exp = exp_p_q.pop_front();
        p_pending = 1'b1;
      end
      resp_cnt++;
    end
  end

  // driver tasks
  task automatic wait_resp(input int target, input int budget);
    for (int i = 0; i < budget && resp_cnt < target; i++) @(negedge clk);
    if (resp_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d expected=%0d", resp_cnt, target);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_one(input logic [W-1:0] nv, input logic [CW-1:0] ecyc, input logic ep);
    int r0;
    @(negedge clk);
    exp_cyc_q.push_back(ecyc);
    exp_t_q.push_back(32'(cyc_cnt) + 32'(ecyc) + 32'd1);
    exp_p_q.push_back(ep);
    r0 = resp_cnt;
    n = nv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_resp(r0 + 1, 300);
  endtask

  initial begin
    int r0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("init_state", 32'(fsm_state), 32'd0);
    check("init_busy", 32'(busy), 32'd0);
    check("init_done", 32'(done), 32'd0);
    check("init_cycles", 32'(cycles), 32'd0);
    @(negedge clk);
    check("idle_state", 32'(fsm_state), 32'd1);
    check("idle_p", 32'(dP), 32'd0);
    check("idle_selects", 32'({a1, a2, a3, a4, a5, a6, a7}), 32'b0001001);

    run_one(8'd2, 16'd4, 1'b1);
    run_one(8'd7, 16'd22, 1'b1);
    n = 8'd4;
    repeat (5) @(negedge clk);
    check("p_hold_idle", 32'(dP), 32'd1);
    run_one(8'd6, 16'd19, 1'b0);
    run_one(8'd1, 16'd0, 1'b0);
    run_one(8'd0, 16'd0, 1'b0);

    // start held high: back-to-back runs, one per IDLE visit
    @(negedge clk);
    exp_cyc_q.push_back(16'd31);
    exp_t_q.push_back(32'(cyc_cnt) + 32'd32);
    exp_p_q.push_back(1'b0);
    exp_cyc_q.push_back(16'd31);
    exp_t_q.push_back(32'(cyc_cnt) + 32'd65);
    exp_p_q.push_back(1'b0);
    r0 = resp_cnt;
    n = 8'd9;
    start = 1'b1;
    repeat (65) @(negedge clk);
    start = 1'b0;
    wait_resp(r0 + 2, 100);

    // reset in the middle of SUB aborts without a done pulse
    @(negedge clk);
    n = 8'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", 32'(fsm_state), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cycles", 32'(cycles), 32'd0);
    repeat (60) @(negedge clk);
    run_one(8'd13, 16'd49, 1'b1);

    check("queue_empty", 32'(exp_cyc_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
